// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Moore control FSM for a multicycle RV32I datapath (lw, sw, R-type,
//   I-type ALU, beq). Each state drives the datapath mux selects, write
//   strobes, ALU op class and immediate format. Memory waits are bounded by
//   a saturating wait counter; an expired wait or an unsupported opcode
//   parks the FSM in a terminal TRAP state with a sticky flag.
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   opcode[6:0]      IR[6:0], stable from DECODE until return to FETCH
//   zero             ALU zero flag (branch resolution)
//   mem_ready        memory completes the current access this cycle
//   pc_write         PC load enable (fetch update or taken branch)
//   ir_write         IR load enable
//   adr_src          memory address select: 0=PC, 1=ALUOut reg
//   mem_write        memory write request
//   reg_write        register file write enable
//   alu_src_a[1:0]   00=PC, 01=oldPC, 10=rs1
//   alu_src_b[1:0]   00=rs2, 01=imm, 10=const 4
//   alu_op[1:0]      00=add, 01=sub, 10=decode funct3/funct7
//   result_src[1:0]  00=ALUOut reg, 01=data reg, 10=ALU result
//   imm_src[1:0]     00=I, 01=S, 10=B
//   illegal          sticky: unsupported opcode trapped
//   bus_err          sticky: mem_ready timeout trapped
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic       bus_err
);

  localparam logic [6:0] op_lw  = 7'b0000011;
  localparam logic [6:0] op_sw  = 7'b0100011;
  localparam logic [6:0] op_r   = 7'b0110011;
  localparam logic [6:0] op_i   = 7'b0010011;
  localparam logic [6:0] op_beq = 7'b1100011;

  typedef enum logic [3:0] {
    st_fetch, st_decode, st_memadr, st_memrd, st_memwb, st_memwr,
    st_exec_r, st_exec_i, st_aluwb, st_beq, st_trap
  } state_t;

  // Per-state control word. 'fetch' and 'branch' are not outputs themselves;
  // they qualify the mem_ready / zero gated strobes.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       fetch;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
  } ctl_t;

  localparam ctl_t ctl_fetch = '{adr_src: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
                                 branch: 1'b0, fetch: 1'b1, alu_src_a: 2'b00,
                                 alu_src_b: 2'b10, alu_op: 2'b00,
                                 result_src: 2'b10, imm_src: 2'b00};

  function automatic ctl_t decode(input state_t s, input logic [6:0] opc);
    ctl_t c;
    c = '0;
    case (s)
      st_fetch:  c = ctl_fetch;
      st_decode: begin  // branch target into ALUOut
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.imm_src   = 2'b10;
      end
      st_memadr: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = (opc == op_sw) ? 2'b01 : 2'b00;
      end
      st_memrd:  c.adr_src = 1'b1;
      st_memwb: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      st_memwr: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      st_exec_r: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      st_exec_i: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      st_aluwb:  c.reg_write = 1'b1;
      st_beq: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      default: ;  // TRAP: everything low
    endcase
    return c;
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == st_fetch) || (s == st_memrd) || (s == st_memwr);
  endfunction

  state_t          state_reg, state_next;
  ctl_t            ctl_reg, ctl_next;
  logic [TO_W-1:0] count_reg, count_next;
  logic            illegal_reg, bus_err_reg;
  logic            illegal_set, bus_err_set;
  logic            timeout;

  always_comb begin
    state_next  = state_reg;
    illegal_set = 1'b0;
    bus_err_set = 1'b0;
    // mem_ready in the same cycle wins over an expiring wait
    timeout = (MEM_TIMEOUT != 0) && (count_reg == TO_W'(MEM_TIMEOUT)) && !mem_ready;
    case (state_reg)
      st_fetch, st_memrd, st_memwr: begin
        if (mem_ready) begin
          case (state_reg)
            st_fetch: state_next = st_decode;
            st_memrd: state_next = st_memwb;
            default:  state_next = st_fetch;
          endcase
        end else if (timeout) begin
          state_next  = st_trap;
          bus_err_set = 1'b1;
        end
      end
      st_decode: begin
        case (opcode)
          op_lw, op_sw: state_next = st_memadr;
          op_r:         state_next = st_exec_r;
          op_i:         state_next = st_exec_i;
          op_beq:       state_next = st_beq;
          default: begin
            state_next  = st_trap;
            illegal_set = 1'b1;
          end
        endcase
      end
      st_memadr:           state_next = (opcode == op_lw) ? st_memrd : st_memwr;
      st_exec_r, st_exec_i: state_next = st_aluwb;
      st_memwb, st_aluwb, st_beq: state_next = st_fetch;
      st_trap:             state_next = st_trap;
      default:             state_next = st_fetch;
    endcase
  end

  // Wait counter: cleared on entry to a wait state, counts mem_ready=0
  // cycles while waiting, saturates at all-ones.
  always_comb begin
    count_next = count_reg;
    if (is_wait(state_next) && (state_next != state_reg))
      count_next = '0;
    else if (is_wait(state_reg) && !mem_ready && (count_reg != '1))
      count_next = count_reg + TO_W'(1);
  end

  // Outputs are registered from the next state so they change with the state
  always_comb ctl_next = decode(state_next, opcode);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= st_fetch;
      ctl_reg     <= ctl_fetch;
      count_reg   <= '0;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctl_reg   <= ctl_next;
      count_reg <= count_next;
      if (illegal_set) illegal_reg <= 1'b1;
      if (bus_err_set) bus_err_reg <= 1'b1;
    end
  end

  // FETCH strobes follow mem_ready combinationally; reset masks them since
  // the FETCH control word is loaded during reset.
  assign ir_write   = ctl_reg.fetch & mem_ready & ~reset;
  assign pc_write   = ~reset & ((ctl_reg.fetch & mem_ready) | (ctl_reg.branch & zero));
  assign adr_src    = ctl_reg.adr_src;
  assign mem_write  = ctl_reg.mem_write;
  assign reg_write  = ctl_reg.reg_write;
  assign alu_src_a  = ctl_reg.alu_src_a;
  assign alu_src_b  = ctl_reg.alu_src_b;
  assign alu_op     = ctl_reg.alu_op;
  assign result_src = ctl_reg.result_src;
  assign imm_src    = ctl_reg.imm_src;
  assign illegal    = illegal_reg;
  assign bus_err    = bus_err_reg;

endmodule
